// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, round-key type, controller
// states, S-box and Rcon lookup.
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  // Index of the final round key, in the width of the round counter/read address.
  localparam logic [3:0] LAST_RK = 4'(NR);

  typedef logic [KEY_W-1:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_t;

  // Forward S-box; the first listed byte lands in element 255, so entry x sits at ~x.
  localparam logic [255:0][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[~x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] value;
    value = 8'h00;
    case (r)
      4'd1:    value = 8'h01;
      4'd2:    value = 8'h02;
      4'd3:    value = 8'h04;
      4'd4:    value = 8'h08;
      4'd5:    value = 8'h10;
      4'd6:    value = 8'h20;
      4'd7:    value = 8'h40;
      4'd8:    value = 8'h80;
      4'd9:    value = 8'h1b;
      4'd10:   value = 8'h36;
      default: value = 8'h00;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_key_expansion.sv
// Combinational AES-128 key expansion step: derives round key r from round key r-1.
// Byte 0 of each word is in the low byte, matching the key_in packing.
module key_expansion
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] prev_key,
  input  logic [3:0]       round,
  output logic [KEY_W-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key[31:0];
  assign w1 = prev_key[63:32];
  assign w2 = prev_key[95:64];
  assign w3 = prev_key[127:96];

  // RotWord moves byte 1 into byte 0; Rcon is applied to byte 0 only.
  assign rot  = {w3[7:0], w3[31:24], w3[23:16], w3[15:8]};
  assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]),
                 sbox(rot[7:0]) ^ rcon(round)};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n3, n2, n1, n0};

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands one key over 10 cycles into an
// 11-entry round-key register file with a registered random-access read port.
// Optional KEY_SCHED_ZEROIZE_EN adds a single-cycle zeroize input.
module key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [3:0]       rk_addr,
  input  logic             rk_rd,
  output logic [KEY_W-1:0] rk_out,
  output logic             rk_out_valid,
  output logic             keys_ready,
  output logic             done
`ifdef KEY_SCHED_ZEROIZE_EN
  ,
  input  logic             zeroize
`endif
);

  ks_state_t        state, next_state;
  logic [3:0]       round_cnt;
  round_key_t       prev_key;
  round_key_t       step_key;
  round_key_t       store [0:NR];
  logic             zero_req;
  logic             accept;
  logic             step_en;
  logic             last_step;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  key_expansion u_key_expansion (
    .prev_key (prev_key),
    .round    (round_cnt),
    .next_key (step_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Zeroize wins over both a pending accept and an expansion in flight.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    last_step  = 1'b0;
    key_ready  = (state != EXPAND);
    case (state)
      IDLE, READY: begin
        if (key_valid) begin
          accept     = 1'b1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        step_en = 1'b1;
        if (round_cnt == LAST_RK) begin
          last_step  = 1'b1;
          next_state = READY;
        end
      end
      default: next_state = IDLE;
    endcase
    if (zero_req) begin
      next_state = IDLE;
      accept     = 1'b0;
      step_en    = 1'b0;
      last_step  = 1'b0;
    end
  end

  // Key store, expansion registers and read port; reads see pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
      prev_key     <= '0;
      round_cnt    <= '0;
      keys_ready   <= 1'b0;
      done         <= 1'b0;
      rk_out       <= '0;
      rk_out_valid <= 1'b0;
    end else if (zero_req) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
      prev_key     <= '0;
      round_cnt    <= '0;
      keys_ready   <= 1'b0;
      done         <= 1'b0;
      rk_out       <= '0;
      rk_out_valid <= 1'b0;
    end else begin
      done <= last_step;
      if (accept) begin
        store[0]   <= key_in;
        prev_key   <= key_in;
        round_cnt  <= 4'd1;
        keys_ready <= 1'b0;
      end else if (step_en) begin
        store[round_cnt] <= step_key;
        prev_key         <= step_key;
        if (last_step) begin
          round_cnt  <= '0;
          keys_ready <= 1'b1;
        end else begin
          round_cnt <= round_cnt + 4'd1;
        end
      end
      rk_out_valid <= rk_rd;
      if (rk_rd) begin
        rk_out <= (rk_addr <= LAST_RK) ? store[rk_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 key vectors (stored byte-reversed).
// Build with KEY_SCHED_ZEROIZE_EN defined to also exercise zeroize.
module tb_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] FIPS_RK1  = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] FIPS_RK10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] JUNK_KEY  = 128'hdeadbeef0123456789abcdeffedcba98;
  // All-zero key: FIPS-order rk1 = 62636363 x4, rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  localparam logic [127:0] ZERO_RK1  = 128'h63636362636363626363636263636362;
  localparam logic [127:0] ZERO_RK10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic         rk_rd;
  logic [127:0] rk_out;
  logic         rk_out_valid;
  logic         keys_ready;
  logic         done;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] expected;
  } rd_vec_t;

  rd_vec_t vecs [5];

  key_schedule_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .rk_addr      (rk_addr),
    .rk_rd        (rk_rd),
    .rk_out       (rk_out),
    .rk_out_valid (rk_out_valid),
    .keys_ready   (keys_ready),
    .done         (done)
`ifdef KEY_SCHED_ZEROIZE_EN
    ,
    .zeroize      (zeroize)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] key, output int acc_cyc);
    key_in    = key;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic readKey(input logic [3:0] addr, output logic [127:0] data, output logic valid);
    rk_addr = addr;
    rk_rd   = 1'b1;
    step();
    data    = rk_out;
    valid   = rk_out_valid;
    rk_rd   = 1'b0;
  endtask

  task automatic waitDone(input int acc_cyc, input string name);
    int got;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) begin
        got = cyc - acc_cyc;
        break;
      end
    end
    checkOutput(name, 128'(got), 128'd10);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_key_ready"},    128'(key_ready),    128'd1);
    checkOutput({tag, "_keys_ready"},   128'(keys_ready),   128'd0);
    checkOutput({tag, "_done"},         128'(done),         128'd0);
    checkOutput({tag, "_rk_out"},       rk_out,             128'd0);
    checkOutput({tag, "_rk_out_valid"}, 128'(rk_out_valid), 128'd0);
  endtask

  initial begin
    int           acc;
    int           nvalid;
    int           ndone;
    logic [127:0] data;
    logic         valid;

    vecs[0] = '{addr: 4'd0,  expected: FIPS_KEY};
    vecs[1] = '{addr: 4'd1,  expected: FIPS_RK1};
    vecs[2] = '{addr: 4'd10, expected: FIPS_RK10};
    vecs[3] = '{addr: 4'd11, expected: 128'd0};
    vecs[4] = '{addr: 4'd15, expected: 128'd0};

    key_in    = '0;
    key_valid = 1'b0;
    rk_addr   = '0;
    rk_rd     = 1'b0;
`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    rst_n     = 1'b0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // FIPS key load with a competing key offered while busy.
    applyStimulus(FIPS_KEY, acc);
    checkOutput("busy_key_ready", 128'(key_ready), 128'd0);
    key_in    = JUNK_KEY;
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("busy_key_ready_hold", 128'(key_ready), 128'd0);
    end
    key_valid = 1'b0;
    waitDone(acc, "fips_done_latency");
    checkOutput("fips_keys_ready", 128'(keys_ready), 128'd1);
    step();
    checkOutput("done_single_pulse", 128'(done), 128'd0);

    for (int i = 0; i < 5; i++) begin
      readKey(vecs[i].addr, data, valid);
      checkOutput($sformatf("table_rk%0d", vecs[i].addr), data, vecs[i].expected);
      checkOutput($sformatf("table_valid%0d", vecs[i].addr), 128'(valid), 128'd1);
    end
    step();
    checkOutput("valid_low_idle", 128'(rk_out_valid), 128'd0);

    // Back-to-back reverse read of all round keys.
    nvalid = 0;
    for (int a = 10; a >= 0; a--) begin
      rk_addr = 4'(a);
      rk_rd   = 1'b1;
      step();
      if (rk_out_valid) nvalid++;
      if (a == 10) checkOutput("rev_rk10", rk_out, FIPS_RK10);
      if (a == 1)  checkOutput("rev_rk1",  rk_out, FIPS_RK1);
      if (a == 0)  checkOutput("rev_rk0",  rk_out, FIPS_KEY);
    end
    rk_rd = 1'b0;
    checkOutput("rev_valid_count", 128'(nvalid), 128'd11);
    step();
    checkOutput("rev_valid_drop", 128'(rk_out_valid), 128'd0);

    // Rekey in READY with the all-zero key; read rk1 on the edge it is rewritten.
    applyStimulus(128'd0, acc);
    checkOutput("rekey_keys_ready_drop", 128'(keys_ready), 128'd0);
    rk_addr = 4'd1;
    rk_rd   = 1'b1;
    step();
    rk_rd = 1'b0;
    checkOutput("read_before_write", rk_out, FIPS_RK1);
    waitDone(acc, "zero_done_latency");
    readKey(4'd10, data, valid);
    checkOutput("zero_rk10", data, ZERO_RK10);
    readKey(4'd1, data, valid);
    checkOutput("zero_rk1", data, ZERO_RK1);

    // Reset during the fifth expansion cycle.
    applyStimulus(FIPS_KEY, acc);
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (keys_ready || done) ndone++;
    end
    checkOutput("midreset_no_ready", 128'(ndone), 128'd0);
    readKey(4'd10, data, valid);
    checkOutput("midreset_store_clear", data, 128'd0);
    applyStimulus(FIPS_KEY, acc);
    waitDone(acc, "reload_done_latency");
    checkOutput("reload_keys_ready", 128'(keys_ready), 128'd1);
    readKey(4'd10, data, valid);
    checkOutput("reload_rk10", data, FIPS_RK10);

`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    checkOutput("zeroize_keys_ready", 128'(keys_ready), 128'd0);
    checkOutput("zeroize_rk_out", rk_out, 128'd0);
    checkOutput("zeroize_valid", 128'(rk_out_valid), 128'd0);
    for (int a = 0; a <= 10; a++) begin
      readKey(4'(a), data, valid);
      checkOutput($sformatf("zeroize_rk%0d", a), data, 128'd0);
    end
    key_in    = FIPS_KEY;
    key_valid = 1'b1;
    zeroize   = 1'b1;
    step();
    key_valid = 1'b0;
    zeroize   = 1'b0;
    checkOutput("zeroize_accept_idle", 128'(key_ready), 128'd1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || keys_ready) ndone++;
    end
    checkOutput("zeroize_accept_no_done", 128'(ndone), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
